mem_stage: RTL and testbench

//  MEM pipeline stage. Sits between EX_MEM and MEM_WB and drives the rd_addr/rd_val/ins_type inputs of MEM_WB.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_load_extend.sv | 20 ++
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode, state and width-decode definitions for the MEM stage and its neighbours.
package mem_stage_pkg;

  localparam logic [6:0]  OP_ALOPI  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Index of the final byte of a transfer; unsupported widths behave as a word.
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Turns the assembled little-endian load buffer into a 32-bit sign/zero-extended result.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  // funct3[2] set selects zero extension.
  always_comb begin
    o_result = i_buf;
    case (i_funct3[1:0])
      2'b00:   o_result = {{24{i_buf[7]  & ~i_funct3[2]}}, i_buf[7:0]};
      2'b01:   o_result = {{16{i_buf[15] & ~i_funct3[2]}}, i_buf[15:0]};
      default: o_result = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an 8-bit controller port, holding the
// pipeline with stall_req while a transfer runs; other instructions pass straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  stall,
  input  logic [6:0]            ins_type,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd_addr,
  input  logic [31:0]           rd_val,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           store_val,
  output logic [4:0]            output_rd_addr,
  output logic [31:0]           output_rd_val,
  output logic [6:0]            output_ins_type,
  output logic                  stall_req,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_ack,
  input  logic [7:0]            mc_rdata
);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] w_load_result;
  logic        w_is_load, w_is_store, w_is_mem;

  assign w_is_load  = (ins_type == OP_LOAD);
  assign w_is_store = (ins_type == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

  mem_stage_load_extend u_load_extend (
    .i_buf    (r_buf),
    .i_funct3 (funct3),
    .o_result (w_load_result)
  );

  // State register; rdy_in low freezes everything, which also ignores mc_ack.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_buf   <= 32'h0000_0000;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Next-state, byte counter and load buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          w_state_nxt = ST_ACCESS;
          w_idx_nxt   = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mc_ack) begin
          if (!w_is_store) begin
            w_buf_nxt[{r_idx, 3'b000} +: 8] = mc_rdata;
          end else begin
            w_buf_nxt = r_buf;
          end
          if (r_idx == last_idx(funct3)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_DONE: begin
        // The stall==0 cycle is the one MEM_WB captures, so leave only then.
        if (!stall) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 2'd0;
          w_buf_nxt   = 32'h0000_0000;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Port muxing; reset forces the bubble/idle values without waiting for a clock edge.
  always_comb begin
    output_ins_type = OP_ALOPI;
    output_rd_addr  = 5'd0;
    output_rd_val   = ZERO_WORD;
    stall_req       = 1'b0;
    mc_req          = 1'b0;
    mc_we           = 1'b0;
    mc_addr         = '0;
    mc_wdata        = 8'h00;
    if (rst_in) begin
      stall_req = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            stall_req = 1'b1;
          end else begin
            output_ins_type = ins_type;
            output_rd_addr  = rd_addr;
            output_rd_val   = rd_val;
          end
        end
        ST_ACCESS: begin
          stall_req = 1'b1;
          mc_req    = rdy_in;
          mc_we     = w_is_store;
          mc_addr   = mem_addr + ADDR_WIDTH'(r_idx);
          mc_wdata  = store_val[{r_idx, 3'b000} +: 8];
        end
        ST_DONE: begin
          if (w_is_load) begin
            output_ins_type = OP_LOAD;
            output_rd_addr  = rd_addr;
            output_rd_val   = w_load_result;
          end else begin
            output_ins_type = OP_STORE;
          end
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a small byte-memory responder model.
module tb_mem_stage;

  localparam logic [6:0] ALOPI = 7'b0010011;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, stall;
  logic [6:0]  ins_type;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val, mem_addr, store_val;
  logic [4:0]  output_rd_addr;
  logic [31:0] output_rd_val;
  logic [6:0]  output_ins_type;
  logic        stall_req, mc_req, mc_we, mc_ack;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata, mc_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  logic [7:0]  mem [0:4095];
  logic [31:0] alog [$];
  logic [39:0] wlog [$];

  always #5 clk_in = ~clk_in;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .ins_type(ins_type), .funct3(funct3), .rd_addr(rd_addr), .rd_val(rd_val),
    .mem_addr(mem_addr), .store_val(store_val),
    .output_rd_addr(output_rd_addr), .output_rd_val(output_rd_val),
    .output_ins_type(output_ins_type), .stall_req(stall_req),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata)
  );

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Controller model: acks any pending request within the same cycle.
  task automatic respond();
    if (mc_req === 1'b1) begin
      mc_ack = 1'b1;
      if (mc_we) begin
        wlog.push_back({mc_addr, mc_wdata});
      end else begin
        mc_rdata = mem[mc_addr[11:0]];
        alog.push_back(mc_addr);
      end
    end else begin
      mc_ack   = 1'b0;
      mc_rdata = 8'h00;
    end
  endtask

  task automatic tick(input bit ack_en);
    @(posedge clk_in);
    #1;
    if (ack_en) respond();
    else mc_ack = 1'b0;
    #1;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] rv, input logic [31:0] sv);
    ins_type = op; funct3 = f3; rd_addr = rd; mem_addr = addr; rd_val = rv; store_val = sv;
    #1;
  endtask

  task automatic run_to_done(output int cycles);
    cycles = 0;
    while (stall_req === 1'b1 && cycles < 40) begin
      cycles++;
      tick(1'b1);
    end
    if (cycles >= 40) chk("timeout", {39'd0, stall_req}, 40'd0);
  endtask

  task automatic leave_done();
    tick(1'b0);
    set_ins(OPR, 3'b000, 5'd1, 32'h0, 32'h0000_0077, 32'h0);
    chk("pass_after", output_rd_val, 40'h77);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; stall = 1'b0; mc_ack = 1'b0; mc_rdata = 8'h00;
    ins_type = LOAD; funct3 = 3'b010; rd_addr = 5'd3; rd_val = 32'h55;
    mem_addr = 32'h10; store_val = 32'h0;
    #1;
    chk("rst_stall", stall_req, 40'd0);
    chk("rst_req", mc_req, 40'd0);
    chk("rst_ins", output_ins_type, {33'd0, ALOPI});
    chk("rst_rd", output_rd_addr, 40'd0);
    chk("rst_val", output_rd_val, 40'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    set_ins(OPR, 3'b000, 5'd5, 32'h0, 32'h0000_1234, 32'h0);
    chk("add_ins", output_ins_type, {33'd0, OPR});
    chk("add_rd", output_rd_addr, 40'd5);
    chk("add_val", output_rd_val, 40'h1234);
    chk("add_stall", stall_req, 40'd0);
    chk("add_req", mc_req, 40'd0);

    mem[12'h100] = 8'h80;
    alog.delete();
    set_ins(LOAD, 3'b000, 5'd7, 32'h100, 32'hDEAD_BEEF, 32'h0);
    chk("lb_stall0", stall_req, 40'd1);
    chk("lb_bubble_ins", output_ins_type, {33'd0, ALOPI});
    chk("lb_bubble_val", output_rd_val, 40'd0);
    run_to_done(cyc);
    chk("lb_cycles", cyc, 40'd2);
    chk("lb_nreq", alog.size(), 40'd1);
    chk("lb_addr", alog[0], 40'h100);
    chk("lb_ins", output_ins_type, {33'd0, LOAD});
    chk("lb_rd", output_rd_addr, 40'd7);
    chk("lb_val", output_rd_val, 40'hFFFF_FF80);
    leave_done();

    mem[12'h200] = 8'h78; mem[12'h201] = 8'h56; mem[12'h202] = 8'h34; mem[12'h203] = 8'h12;
    alog.delete();
    set_ins(LOAD, 3'b010, 5'd10, 32'h200, 32'hDEAD_BEEF, 32'h0);
    run_to_done(cyc);
    chk("lw_cycles", cyc, 40'd5);
    chk("lw_nreq", alog.size(), 40'd4);
    for (int i = 0; i < 4; i++) chk("lw_addr", alog[i], 40'h200 + 40'(i));
    chk("lw_val", output_rd_val, 40'h1234_5678);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("hold_val", output_rd_val, 40'h1234_5678);
      chk("hold_req", mc_req, 40'd0);
      chk("hold_stall", stall_req, 40'd0);
    end
    chk("hold_nreq", alog.size(), 40'd4);
    stall = 1'b0;
    #1;
    chk("drop_val", output_rd_val, 40'h1234_5678);
    tick(1'b0);
    chk("exit_idle", stall_req, 40'd1);
    chk("exit_ins", output_ins_type, {33'd0, ALOPI});
    set_ins(OPR, 3'b000, 5'd1, 32'h0, 32'h0000_0077, 32'h0);
    chk("exit_pass", output_rd_val, 40'h77);

    mem[12'h200] = 8'h00; mem[12'h201] = 8'h80;
    set_ins(LOAD, 3'b101, 5'd11, 32'h200, 32'hDEAD_BEEF, 32'h0);
    run_to_done(cyc);
    chk("lhu_cycles", cyc, 40'd3);
    chk("lhu_val", output_rd_val, 40'h0000_8000);
    leave_done();
    set_ins(LOAD, 3'b001, 5'd11, 32'h200, 32'hDEAD_BEEF, 32'h0);
    run_to_done(cyc);
    chk("lh_val", output_rd_val, 40'hFFFF_8000);
    leave_done();

    wlog.delete();
    set_ins(STORE, 3'b001, 5'd9, 32'h300, 32'hDEAD_BEEF, 32'hAABB_CCDD);
    run_to_done(cyc);
    chk("sh_nwr", wlog.size(), 40'd2);
    chk("sh_w0", wlog[0], {32'h300, 8'hDD});
    chk("sh_w1", wlog[1], {32'h301, 8'hCC});
    chk("sh_ins", output_ins_type, {33'd0, STORE});
    chk("sh_rd", output_rd_addr, 40'd0);
    chk("sh_val", output_rd_val, 40'd0);
    leave_done();

    mem[12'h200] = 8'h78; mem[12'h201] = 8'h56;
    alog.delete();
    set_ins(LOAD, 3'b010, 5'd12, 32'h200, 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    mc_ack = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("arst_req", mc_req, 40'd0);
    chk("arst_stall", stall_req, 40'd0);
    chk("arst_ins", output_ins_type, {33'd0, ALOPI});
    chk("arst_val", output_rd_val, 40'd0);
    rst_in = 1'b0;
    #1;
    alog.delete();
    run_to_done(cyc);
    chk("arst_cycles", cyc, 40'd5);
    chk("arst_first", alog[0], 40'h200);
    chk("arst_lw_val", output_rd_val, 40'h1234_5678);
    leave_done();

    alog.delete();
    set_ins(LOAD, 3'b010, 5'd13, 32'h200, 32'hDEAD_BEEF, 32'h0);
    tick(1'b1);
    tick(1'b0);
    rdy_in = 1'b0;
    #1;
    chk("frz_req0", mc_req, 40'd0);
    tick(1'b0);
    chk("frz_req1", mc_req, 40'd0);
    tick(1'b0);
    chk("frz_req2", mc_req, 40'd0);
    chk("frz_stall", stall_req, 40'd1);
    rdy_in = 1'b1;
    #1;
    chk("frz_resume_req", mc_req, 40'd1);
    chk("frz_resume_addr", mc_addr, 40'h201);
    run_to_done(cyc);
    chk("frz_nreq", alog.size(), 40'd4);
    chk("frz_val", output_rd_val, 40'h1234_5678);
    leave_done();

    mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h12;
    alog.delete();
    set_ins(LOAD, 3'b001, 5'd14, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0);
    run_to_done(cyc);
    chk("wrap_addr", alog[1], 40'h0);
    chk("wrap_val", output_rd_val, 40'h0000_1234);
    leave_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
